// File: rtl/pseudo_softmax_stream.sv
// pseudo_softmax_stream
//
// Streaming, time-multiplexed pseudo-softmax over log-domain inputs.
// A vector of 1..DEPTH elements x_i (each standing for 2^x_i) is buffered
// while the exact sum S is accumulated.  S is then normalised to 1.M * 2^E,
// and one result per element is emitted as an exponent offset E - x_i
// together with a shared reciprocal mantissa r, where 0.r ~= 1 - 0.M/2.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   input element valid
//   in_ready   block accepts input (only while collecting)
//   in_data    x_i, unsigned IN_WIDTH
//   in_last    final element of the vector
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_exp    E - x_i for the current element
//   out_mant   reciprocal mantissa r, shared by the whole vector
//   out_last   final result of the vector
//   busy       high while normalising or emitting
module pseudo_softmax_stream #(
    parameter int DEPTH      = 8,
    parameter int IN_WIDTH   = 4,
    parameter int EXP_WIDTH  = 5,
    parameter int MANT_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [EXP_WIDTH-1:0]  out_exp,
    output logic [MANT_WIDTH-1:0] out_mant,
    output logic                  out_last,
    output logic                  busy
);

    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ACC_W = (1 << IN_WIDTH) + CNT_W;
    localparam int IDX_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_NORM    = 2'd1;
    localparam logic [1:0] ST_EMIT    = 2'd2;

    logic [1:0]            state;
    logic [IN_WIDTH-1:0]   data_buf [DEPTH];
    logic [ACC_W-1:0]      acc;
    logic [CNT_W-1:0]      wr_cnt;
    logic [CNT_W-1:0]      rd_idx;
    logic [CNT_W-1:0]      last_idx;
    logic [EXP_WIDTH-1:0]  e_reg;
    logic [MANT_WIDTH-1:0] r_reg;
    logic                  in_ready_q;

    logic [EXP_WIDTH-1:0]  e_next;
    logic [MANT_WIDTH-1:0] m_next;
    logic [MANT_WIDTH-1:0] r_next;

    // Normalisation of the accumulated sum.  The highest set bit of acc gives
    // E; the MANT_WIDTH bits right below it form the truncated fraction M,
    // with positions below bit 0 reading as zero for small sums.  The
    // reciprocal is a single-segment line: r = all-ones - M/2.
    always_comb begin
        int lead;
        int idx;
        lead   = 0;
        idx    = 0;
        m_next = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc[i]) begin
                lead = i;
            end
        end
        for (int j = 0; j < MANT_WIDTH; j++) begin
            idx = lead - 1 - j;
            if (idx >= 0) begin
                m_next[MANT_WIDTH-1-j] = acc[IDX_W'(idx)];
            end
        end
        e_next = EXP_WIDTH'(lead);
        r_next = {MANT_WIDTH{1'b1}} - (m_next >> 1);
    end

    // Main controller.  in_ready is held in a flop so that it is low during
    // reset, rises on the first edge after release, and is re-armed on the
    // same edge that accepts the final result, giving bubble-free turnaround.
    // A full buffer closes the vector regardless of in_last.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_COLLECT;
            in_ready_q <= 1'b0;
            acc        <= '0;
            wr_cnt     <= '0;
            rd_idx     <= '0;
            last_idx   <= '0;
            e_reg      <= '0;
            r_reg      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_buf[i] <= '0;
            end
        end else begin
            case (state)
                ST_COLLECT: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        data_buf[wr_cnt] <= in_data;
                        acc              <= acc + (ACC_W'(1) << in_data);
                        wr_cnt           <= wr_cnt + 1'b1;
                        if (in_last || (wr_cnt == LAST_SLOT)) begin
                            last_idx   <= wr_cnt;
                            state      <= ST_NORM;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                ST_NORM: begin
                    e_reg  <= e_next;
                    r_reg  <= r_next;
                    rd_idx <= '0;
                    state  <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (rd_idx == last_idx) begin
                            acc        <= '0;
                            wr_cnt     <= '0;
                            rd_idx     <= '0;
                            state      <= ST_COLLECT;
                            in_ready_q <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= ST_COLLECT;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // Outputs decode registered state only; results are forced to zero
    // outside EMIT so nothing stale is visible between vectors.
    assign in_ready  = in_ready_q;
    assign out_valid = (state == ST_EMIT);
    assign out_exp   = out_valid ? (e_reg - EXP_WIDTH'(data_buf[rd_idx])) : '0;
    assign out_mant  = out_valid ? r_reg : '0;
    assign out_last  = out_valid && (rd_idx == last_idx);
    assign busy      = (state != ST_COLLECT);

endmodule

// File: tb/tb_pseudo_softmax_stream.sv
// tb_pseudo_softmax_stream
//
// Directed bench for pseudo_softmax_stream with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pseudo_softmax_stream;

    localparam int DEPTH      = 8;
    localparam int IN_WIDTH   = 4;
    localparam int EXP_WIDTH  = 5;
    localparam int MANT_WIDTH = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [IN_WIDTH-1:0]   in_data;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [EXP_WIDTH-1:0]  out_exp;
    logic [MANT_WIDTH-1:0] out_mant;
    logic                  out_last;
    logic                  busy;

    int checks = 0;
    int errors = 0;

    pseudo_softmax_stream #(
        .DEPTH      (DEPTH),
        .IN_WIDTH   (IN_WIDTH),
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_exp   (out_exp),
        .out_mant  (out_mant),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts, and reports on mismatch.
    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Offer one element for a single cycle; it must be accepted.
    task automatic applyStimulus(input logic [IN_WIDTH-1:0] x, input logic last);
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        check("in_ready_on_offer", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check the presented result, then consume it with a one-cycle ready.
    task automatic checkOutput(input string tag, input int e, input int m, input logic last);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_exp"},   {27'd0, out_exp},   32'(e));
        check({tag, "_mant"},  {29'd0, out_mant},  32'(m));
        check({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        $display("[TB] reset values");
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last",  {31'd0, out_last},  32'd0);
        check("rst_out_exp",   {27'd0, out_exp},   32'd0);
        check("rst_out_mant",  {29'd0, out_mant},  32'd0);
        check("rst_busy",      {31'd0, busy},      32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // {3}: S=8, E=3, M=0, r=7; result one cycle after NORM
        $display("[TB] single element");
        applyStimulus(4'd3, 1'b1);
        check("t1_norm_valid", {31'd0, out_valid}, 32'd0);
        check("t1_norm_busy",  {31'd0, busy},      32'd1);
        check("t1_norm_ready", {31'd0, in_ready},  32'd0);
        @(negedge clk);
        checkOutput("t1_r0", 0, 7, 1'b1);
        check("t1_done_valid", {31'd0, out_valid}, 32'd0);
        check("t1_done_ready", {31'd0, in_ready},  32'd1);
        check("t1_done_busy",  {31'd0, busy},      32'd0);

        // {0,1,2}: S=7, E=2, M=110, r=4
        $display("[TB] vector 0,1,2");
        applyStimulus(4'd0, 1'b0);
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b1);
        @(negedge clk);
        checkOutput("t2_r0", 2, 4, 1'b0);
        checkOutput("t2_r1", 1, 4, 1'b0);
        checkOutput("t2_r2", 0, 4, 1'b1);

        // Eight 15s with no in_last: S=2^18, E=18, r=7, forced end
        $display("[TB] full buffer");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(4'd15, 1'b0);
        end
        check("t3_full_ready", {31'd0, in_ready},  32'd0);
        check("t3_norm_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("t3_r", 3, 7, (i == DEPTH - 1));
        end
        check("t3_done_valid", {31'd0, out_valid}, 32'd0);

        // {2,2} with back-pressure: S=8, E=3, r=7, out_exp=1
        $display("[TB] back-pressure");
        applyStimulus(4'd2, 1'b0);
        applyStimulus(4'd2, 1'b1);
        @(negedge clk);
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 5; k++) begin
                in_valid = (k % 2 == 0);
                in_data  = 4'd9;
                in_last  = 1'b1;
                check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
                check("t4_hold_exp",   {27'd0, out_exp},   32'd1);
                check("t4_hold_mant",  {29'd0, out_mant},  32'd7);
                check("t4_hold_last",  {31'd0, out_last},  32'(r == 1));
                check("t4_hold_ready", {31'd0, in_ready},  32'd0);
                @(negedge clk);
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            checkOutput("t4_r", 1, 7, (r == 1));
        end
        check("t4_done_valid", {31'd0, out_valid}, 32'd0);
        check("t4_done_ready", {31'd0, in_ready},  32'd1);

        // {1,2,3}: S=14, E=3, M=110, r=4; reset after first result
        $display("[TB] reset during emit");
        applyStimulus(4'd1, 1'b0);
        applyStimulus(4'd2, 1'b0);
        applyStimulus(4'd3, 1'b1);
        @(negedge clk);
        checkOutput("t5_r0", 2, 4, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("t5_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t5_rst_busy",  {31'd0, busy},      32'd0);
        check("t5_rst_exp",   {27'd0, out_exp},   32'd0);
        check("t5_rst_ready", {31'd0, in_ready},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_rel_ready", {31'd0, in_ready},  32'd1);
        check("t5_rel_valid", {31'd0, out_valid}, 32'd0);
        applyStimulus(4'd5, 1'b1);
        @(negedge clk);
        checkOutput("t5_fresh", 0, 7, 1'b1);

        // {4,4} then {1} back to back: S=32 -> exp 1, r 7; then S=2 -> exp 0, r 7
        $display("[TB] back-to-back vectors");
        applyStimulus(4'd4, 1'b0);
        applyStimulus(4'd4, 1'b1);
        @(negedge clk);
        checkOutput("t6_a0", 1, 7, 1'b0);
        checkOutput("t6_a1", 1, 7, 1'b1);
        applyStimulus(4'd1, 1'b1);
        @(negedge clk);
        checkOutput("t6_b0", 0, 7, 1'b1);
        check("t6_done_valid", {31'd0, out_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
